// File: rtl/rca_digit_serial_adder_if.sv
// Handshake bundle for rca_digit_serial_adder: operand side (in_*, a, b, cin)
// and result side (out_*, sum, carry, overflow).
// Optional macro RCA_SERIAL_SUB_EN adds the 1-bit 'sub' operand signal.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds valid and its data stable until that edge, and
// ready never depends combinationally on valid.
interface rca_digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef RCA_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
`ifdef RCA_SERIAL_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
`ifdef RCA_SERIAL_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/rca_digit_serial_adder.sv
// Digit-serial ripple-carry adder: {carry,sum} = a + b + cin, DIGIT bits per
// clock through one DIGIT-bit ripple slice with a registered inter-digit carry.
// WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH.
// Optional macro RCA_SERIAL_SUB_EN: adds 'sub' (b inverted, cin inverted) so
// the block also computes a-b / a-b-1; carry then reads as NOT borrow.
// state_dbg mirrors the FSM state (0=IDLE, 1=RUN, 2=DONE).
module rca_digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    rca_digit_serial_adder_if.slave    bus,
    output logic [1:0]                 state_dbg
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;

    logic               sub_in;
    logic [DIGIT-1:0]   slice_sum;
    logic [DIGIT:0]     slice_c;
    logic [WIDTH-1:0]   res_shift;
    logic               last_digit;
    logic               unused_res_low;

`ifdef RCA_SERIAL_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // One DIGIT-bit ripple slice over the low digit of the operand registers.
    always_comb begin
        slice_c    = '0;
        slice_sum  = '0;
        slice_c[0] = c_q;
        for (int i = 0; i < DIGIT; i++) begin
            slice_sum[i]  = a_q[i] ^ b_q[i] ^ slice_c[i];
            slice_c[i+1]  = (a_q[i] & b_q[i]) | (slice_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters at the top; after NDIG shifts digit 0 sits at bit 0.
    // The low digit of res_q is always shifted out and never read.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_shift      = slice_sum;
            assign unused_res_low = ^res_q;
        end else begin : g_multi
            assign res_shift      = {slice_sum, res_q[WIDTH-1:DIGIT]};
            assign unused_res_low = ^res_q[DIGIT-1:0];
        end
    endgenerate

    assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

    // Next-state and datapath update for IDLE / RUN / DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction folds into the operands once, at acceptance.
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{sub_in}};
                    c_d     = bus.cin ^ sub_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = slice_c[DIGIT];
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (last_digit) begin
                    // Bit DIGIT-1 of the final slice is bit WIDTH-1 overall.
                    sum_d      = res_shift;
                    carry_d    = slice_c[DIGIT];
                    overflow_d = slice_c[DIGIT-1] ^ slice_c[DIGIT];
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_rca_digit_serial_adder.sv
// Bench for rca_digit_serial_adder: WIDTH=16/DIGIT=4 main instance plus a
// WIDTH=16/DIGIT=16 instance for the single-digit case.
module tb_rca_digit_serial_adder;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rca_digit_serial_adder_if #(.WIDTH(W)) dif ();
    rca_digit_serial_adder_if #(.WIDTH(W)) wif ();
    logic [1:0] st_dbg;
    logic [1:0] wst_dbg;

    rca_digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (dif.slave),
        .state_dbg (st_dbg)
    );

    rca_digit_serial_adder #(.WIDTH(W), .DIGIT(W)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .bus       (wif.slave),
        .state_dbg (wst_dbg)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    int acc_cyc = 0;
    logic [17:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] eb;
        logic [16:0] full;
        logic        ov;
        eb   = b ^ {16{sub}};
        full = {1'b0, a} + {1'b0, eb} + {16'd0, cin ^ sub};
        ov   = (a[15] == eb[15]) && (full[15] != a[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input bit push);
        int n;
        n = 0;
        while (dif.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_val("in_ready_timeout", {31'd0, dif.in_ready}, 32'd1);
        dif.a        = a;
        dif.b        = b;
        dif.cin      = cin;
`ifdef RCA_SERIAL_SUB_EN
        dif.sub      = sub;
`endif
        dif.in_valid = 1'b1;
        if (push) exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk); #1;
        acc_cyc      = cyc;
        dif.in_valid = 1'b0;
        dif.a        = 16'hDEAD;
        dif.b        = 16'hBEEF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst) begin
            if (dif.out_valid && !prev_ov)
                check_val("latency", cyc - acc_cyc, NDIG);
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", {31'd0, dif.out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sum",      {16'd0, dif.sum},      {16'd0, e[15:0]});
                    check_val("carry",    {31'd0, dif.carry},    {31'd0, e[16]});
                    check_val("overflow", {31'd0, dif.overflow}, {31'd0, e[17]});
                end
            end
        end
        prev_ov = dif.out_valid;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [17:0] e;
        logic        s;
        int          n;

        dif.in_valid = 1'b0; dif.a = '0; dif.b = '0; dif.cin = 1'b0; dif.out_ready = 1'b1;
        wif.in_valid = 1'b0; wif.a = '0; wif.b = '0; wif.cin = 1'b0; wif.out_ready = 1'b1;
`ifdef RCA_SERIAL_SUB_EN
        dif.sub = 1'b0;
        wif.sub = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready",  {31'd0, dif.in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        check_val("rst_sum",       {16'd0, dif.sum},       32'd0);
        check_val("rst_carry",     {31'd0, dif.carry},     32'd0);
        check_val("rst_overflow",  {31'd0, dif.overflow},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed and random additions.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
`ifdef RCA_SERIAL_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), s, 1'b1);
        end
        drain();

        // Backpressure: result held, new operands ignored.
        dif.out_ready = 1'b0;
        send(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1);
        e = exp_q[0];
        n = 0;
        while (dif.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_wait", {31'd0, dif.out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_out_valid", {31'd0, dif.out_valid}, 32'd1);
            check_val("bp_in_ready",  {31'd0, dif.in_ready},  32'd0);
            check_val("bp_sum",       {16'd0, dif.sum},       {16'd0, e[15:0]});
            check_val("bp_carry",     {31'd0, dif.carry},     {31'd0, e[16]});
            @(posedge clk); #1;
            dif.in_valid = (k % 2 == 0);
            dif.a        = 16'($urandom_range(0, 65535));
            dif.b        = 16'($urandom_range(0, 65535));
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check_val("hs_in_ready_before", {31'd0, dif.in_ready}, 32'd0);
        @(negedge clk);
        check_val("hs_in_ready_after",  {31'd0, dif.in_ready},  32'd1);
        check_val("hs_out_valid_after", {31'd0, dif.out_valid}, 32'd0);
        check_val("idle_sum_held",      {16'd0, dif.sum},       {16'd0, e[15:0]});
        repeat (3) @(negedge clk);
        check_val("ignored_no_op", {31'd0, dif.out_valid}, 32'd0);
        check_val("bp_queue",      exp_q.size(),           0);

        // Reset during the second RUN cycle.
        @(posedge clk); #1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_in_ready", {31'd0, dif.in_ready},  32'd1);
        check_val("mid_rst_valid",    {31'd0, dif.out_valid}, 32'd0);
        check_val("mid_rst_sum",      {16'd0, dif.sum},       32'd0);
        check_val("mid_rst_state",    {30'd0, st_dbg},        32'd0);
        repeat (6) @(negedge clk);
        check_val("mid_rst_no_valid", {31'd0, dif.out_valid}, 32'd0);
        @(posedge clk); #1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        check_val("rerun_model", {14'd0, exp_q[exp_q.size()-1]}, {14'd0, 18'h02345});
        drain();

`ifdef RCA_SERIAL_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        // Single-digit instance: result one cycle after acceptance.
        @(negedge clk);
        check_val("w_in_ready", {31'd0, wif.in_ready}, 32'd1);
        @(posedge clk); #1;
        wif.a = 16'h7FFF; wif.b = 16'h0001; wif.cin = 1'b1; wif.in_valid = 1'b1;
        e = model(16'h7FFF, 16'h0001, 1'b1, 1'b0);
        @(posedge clk); #1;
        wif.in_valid = 1'b0;
        @(negedge clk);
        check_val("w_run_no_valid", {31'd0, wif.out_valid}, 32'd0);
        @(negedge clk);
        check_val("w_out_valid", {31'd0, wif.out_valid}, 32'd1);
        check_val("w_sum",       {16'd0, wif.sum},       {16'd0, e[15:0]});
        check_val("w_carry",     {31'd0, wif.carry},     {31'd0, e[16]});
        check_val("w_overflow",  {31'd0, wif.overflow},  {31'd0, e[17]});

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
